// File: rtl/duty_ramp_pkg.sv
// Shared types and helpers for the duty ramp controller that feeds pwm_gen.
// Holds the FSM state encoding, default duty limits and the target clamp.
package duty_ramp_pkg;

    localparam int DUTY_W_DEF   = 8;
    localparam int DUTY_MAX_DEF = 100;
    localparam int DUTY_MIN_DEF = 0;
    localparam int IVL_W_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_ESTOP = 2'd2
    } ramp_state_t;

    // Saturate a signed duty request into [lo, hi]
    function automatic logic signed [DUTY_W_DEF-1:0] clamp_duty(
        input logic signed [DUTY_W_DEF-1:0] v,
        input logic signed [DUTY_W_DEF-1:0] lo,
        input logic signed [DUTY_W_DEF-1:0] hi
    );
        logic signed [DUTY_W_DEF-1:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/duty_ramp_ctrl_ramp_tick_gen.sv
// Step prescaler: emits a one-cycle tick every eff_interval clocks while enabled.
// The tick is combinational from the count so a step lands exactly eff_interval edges after a restart.
module ramp_tick_gen #(
    parameter int IVL_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [IVL_W-1:0] interval,
    output logic             tick
);

    localparam logic [IVL_W-1:0] ONE_C = {{(IVL_W-1){1'b0}}, 1'b1};

    logic [IVL_W-1:0] cnt_r;
    logic [IVL_W-1:0] eff_ivl_s;
    logic [IVL_W-1:0] last_s;
    logic             tick_s;

    // Effective interval and terminal-count detect; >= tolerates an interval shrinking mid-count
    always_comb begin
        eff_ivl_s = interval;
        if (interval == {IVL_W{1'b0}}) begin
            eff_ivl_s = ONE_C;
        end else begin
            eff_ivl_s = interval;
        end
        last_s = eff_ivl_s - ONE_C;
        tick_s = enable && (cnt_r >= last_s);
    end

    // Prescaler count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {IVL_W{1'b0}};
        end else if (clear || !enable || tick_s) begin
            cnt_r <= {IVL_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + ONE_C;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/duty_ramp_ctrl.sv
// Slew-limited duty command for pwm_gen: accepts clamped targets over valid/ready,
// ramps duty_cycle toward them at a programmable rate, and forces zero on estop.
module duty_ramp_ctrl
    import duty_ramp_pkg::*;
#(
    parameter int DUTY_W   = DUTY_W_DEF,
    parameter int DUTY_MAX = DUTY_MAX_DEF,
    parameter int DUTY_MIN = DUTY_MIN_DEF,
    parameter int IVL_W    = IVL_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DUTY_W-1:0] target_duty,
    input  logic                     target_valid,
    output logic                     target_ready,
    input  logic [3:0]               step,
    input  logic [IVL_W-1:0]         interval,
    input  logic                     estop,
    output logic signed [DUTY_W-1:0] duty_cycle,
    output logic                     busy,
    output logic                     at_target
);

    localparam logic signed [DUTY_W-1:0] MAX_C = DUTY_W'(DUTY_MAX);
    localparam logic signed [DUTY_W-1:0] MIN_C = DUTY_W'(DUTY_MIN);

    ramp_state_t               state_r, state_n_s;
    logic signed [DUTY_W-1:0]  duty_r, duty_n_s;
    logic signed [DUTY_W-1:0]  tgt_r, tgt_n_s;
    logic                      busy_r, at_target_r;

    logic                      ready_s, xfer_s, tick_s, tick_clear_s;
    logic signed [DUTY_W-1:0]  tgt_in_s;
    logic signed [DUTY_W:0]    diff_s;
    logic [DUTY_W:0]           mag_s, eff_step_s, move_s;
    logic signed [DUTY_W-1:0]  stepped_s;

    assign ready_s      = !reset && !estop && (state_r != ST_ESTOP);
    assign xfer_s       = target_valid && ready_s;
    assign tgt_in_s     = clamp_duty(target_duty, MIN_C, MAX_C);
    assign tick_clear_s = xfer_s || estop;

    ramp_tick_gen #(.IVL_W(IVL_W)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .clear    (tick_clear_s),
        .enable   (state_r == ST_RAMP),
        .interval (interval),
        .tick     (tick_s)
    );

    // One slew step toward the target: 9-bit signed difference, move = min(eff_step, |diff|)
    always_comb begin
        diff_s     = {tgt_r[DUTY_W-1], tgt_r} - {duty_r[DUTY_W-1], duty_r};
        mag_s      = diff_s[DUTY_W] ? (DUTY_W+1)'(-diff_s) : (DUTY_W+1)'(diff_s);
        eff_step_s = (step == 4'd0) ? (DUTY_W+1)'(1) : (DUTY_W+1)'(step);
        move_s     = (eff_step_s < mag_s) ? eff_step_s : mag_s;
        if (diff_s[DUTY_W]) begin
            stepped_s = duty_r - DUTY_W'(move_s);
        end else begin
            stepped_s = duty_r + DUTY_W'(move_s);
        end
    end

    // Next-state and datapath; estop overrides everything, a transfer beats a tick
    always_comb begin
        state_n_s = state_r;
        duty_n_s  = duty_r;
        tgt_n_s   = tgt_r;
        if (estop) begin
            state_n_s = ST_ESTOP;
            duty_n_s  = '0;
            tgt_n_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        tgt_n_s   = tgt_in_s;
                        state_n_s = (tgt_in_s != duty_r) ? ST_RAMP : ST_IDLE;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_RAMP: begin
                    if (xfer_s) begin
                        tgt_n_s   = tgt_in_s;
                        state_n_s = (tgt_in_s != duty_r) ? ST_RAMP : ST_IDLE;
                    end else if (tick_s) begin
                        duty_n_s  = stepped_s;
                        state_n_s = (stepped_s == tgt_r) ? ST_IDLE : ST_RAMP;
                    end else begin
                        state_n_s = ST_RAMP;
                    end
                end
                ST_ESTOP: begin
                    state_n_s = ST_IDLE;
                end
                default: begin
                    state_n_s = ST_IDLE;
                    duty_n_s  = '0;
                    tgt_n_s   = '0;
                end
            endcase
        end
    end

    // State, duty and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            duty_r      <= '0;
            tgt_r       <= '0;
            busy_r      <= 1'b0;
            at_target_r <= 1'b1;
        end else begin
            state_r     <= state_n_s;
            duty_r      <= duty_n_s;
            tgt_r       <= tgt_n_s;
            busy_r      <= (state_n_s == ST_RAMP);
            at_target_r <= (duty_n_s == tgt_n_s) && (state_n_s != ST_ESTOP);
        end
    end

    assign target_ready = ready_s;
    assign duty_cycle   = duty_r;
    assign busy         = busy_r;
    assign at_target    = at_target_r;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Self-checking bench for duty_ramp_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the ramp rules.
module tb_duty_ramp_ctrl;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic signed [7:0] target_duty = 8'sd0;
    logic              target_valid = 1'b0;
    logic              target_ready;
    logic [3:0]        step = 4'd1;
    logic [15:0]       interval = 16'd1;
    logic              estop = 1'b0;
    logic signed [7:0] duty_cycle;
    logic              busy;
    logic              at_target;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    int m_duty = 0, m_tgt = 0, m_wait = 0;
    bit m_ramp = 0, m_estop = 0;

    duty_ramp_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .target_duty  (target_duty),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .step         (step),
        .interval     (interval),
        .estop        (estop),
        .duty_cycle   (duty_cycle),
        .busy         (busy),
        .at_target    (at_target)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and apply the ramp rules to the model
    task automatic cycle();
        bit xfer;
        int t, ei, es, diff, mag, mv;
        xfer = target_valid && !reset && !estop && !m_estop;
        t = int'(target_duty);
        if (t < 0) t = 0;
        if (t > 100) t = 100;
        ei = (interval == 16'd0) ? 1 : int'(interval);
        es = (step == 4'd0) ? 1 : int'(step);
        @(posedge clk);
        if (reset) begin
            m_duty = 0; m_tgt = 0; m_wait = 0; m_ramp = 0; m_estop = 0;
        end else if (estop) begin
            m_duty = 0; m_tgt = 0; m_ramp = 0; m_estop = 1;
        end else if (m_estop) begin
            m_estop = 0;
        end else if (xfer) begin
            m_tgt = t; m_wait = 0; m_ramp = (t != m_duty);
        end else if (m_ramp) begin
            m_wait++;
            if (m_wait >= ei) begin
                m_wait = 0;
                diff = m_tgt - m_duty;
                mag = (diff < 0) ? -diff : diff;
                mv = (es < mag) ? es : mag;
                m_duty += (diff > 0) ? mv : -mv;
                if (m_duty == m_tgt) m_ramp = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle(); cycle();
        n_checks++; if (duty_cycle !== 8'sd0) begin n_fail++; $display("FAIL reset_duty got %0d want 0", duty_cycle); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL reset_at_target got %b want 1", at_target); end
        n_checks++; if (target_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", target_ready); end
        reset = 1'b0;
        #1;
        n_checks++; if (target_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %b want 1", target_ready); end
    endtask

    task automatic test_ramp_basic();
        step = 4'd5; interval = 16'd4; target_duty = 8'sd50; target_valid = 1'b1;
        cycle();
        target_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            cycle();
            n_checks++; if (int'(duty_cycle) != m_duty) begin n_fail++; $display("FAIL ramp_model edge %0d got %0d want %0d", n, duty_cycle, m_duty); end
            if (n % 4 == 0) begin
                n_checks++; if (int'(duty_cycle) != (n / 4) * 5) begin n_fail++; $display("FAIL ramp_step edge %0d got %0d want %0d", n, duty_cycle, (n / 4) * 5); end
            end
            if (n < 40) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ramp_busy edge %0d got %b want 1", n, busy); end
            end
        end
        n_checks++; if (busy !== 1'b0 || at_target !== 1'b1) begin n_fail++; $display("FAIL ramp_done busy=%b at_target=%b want 0/1", busy, at_target); end
    endtask

    task automatic test_reverse();
        step = 4'd10; interval = 16'd1; target_duty = 8'sd100; target_valid = 1'b1;
        cycle();
        target_valid = 1'b0;
        cycle();
        n_checks++; if (duty_cycle !== 8'sd60) begin n_fail++; $display("FAIL rev_reach60 got %0d want 60", duty_cycle); end
        target_duty = 8'sd0; target_valid = 1'b1;
        cycle();
        target_valid = 1'b0;
        n_checks++; if (duty_cycle !== 8'sd60) begin n_fail++; $display("FAIL rev_xfer_hold got %0d want 60", duty_cycle); end
        for (int e = 50; e >= 0; e -= 10) begin
            cycle();
            n_checks++; if (int'(duty_cycle) != e || m_duty != e) begin n_fail++; $display("FAIL rev_down got %0d want %0d", duty_cycle, e); end
        end
        n_checks++; if (busy !== 1'b0 || at_target !== 1'b1) begin n_fail++; $display("FAIL rev_done busy=%b at_target=%b want 0/1", busy, at_target); end
    endtask

    task automatic test_clamp();
        target_duty = -8'sd20; target_valid = 1'b1;
        cycle();
        target_valid = 1'b0;
        cycle();
        n_checks++; if (duty_cycle !== 8'sd0 || busy !== 1'b0 || at_target !== 1'b1) begin n_fail++; $display("FAIL clamp_neg duty=%0d busy=%b at=%b want 0/0/1", duty_cycle, busy, at_target); end
        step = 4'd10; interval = 16'd1; target_duty = 8'sd90; target_valid = 1'b1;
        cycle();
        target_valid = 1'b0;
        for (int n = 0; n < 9; n++) cycle();
        n_checks++; if (duty_cycle !== 8'sd90) begin n_fail++; $display("FAIL clamp_reach90 got %0d want 90", duty_cycle); end
        step = 4'd15; target_duty = 8'sd127; target_valid = 1'b1;
        cycle();
        target_valid = 1'b0;
        cycle();
        n_checks++; if (duty_cycle !== 8'sd100) begin n_fail++; $display("FAIL clamp_overshoot got %0d want 100", duty_cycle); end
        cycle();
        n_checks++; if (duty_cycle !== 8'sd100 || busy !== 1'b0 || at_target !== 1'b1) begin n_fail++; $display("FAIL clamp_hold duty=%0d busy=%b at=%b want 100/0/1", duty_cycle, busy, at_target); end
    endtask

    task automatic test_estop();
        int guard = 0;
        step = 4'd10; interval = 16'd2; target_duty = 8'sd0; target_valid = 1'b1;
        cycle();
        target_valid = 1'b0;
        while (m_duty != 40 && guard < 40) begin cycle(); guard++; end
        n_checks++; if (guard >= 40 || duty_cycle !== 8'sd40) begin n_fail++; $display("FAIL estop_reach40 got %0d want 40", duty_cycle); end
        estop = 1'b1; target_duty = 8'sd80; target_valid = 1'b1;
        cycle();
        n_checks++; if (duty_cycle !== 8'sd0 || target_ready !== 1'b0) begin n_fail++; $display("FAIL estop_force duty=%0d ready=%b want 0/0", duty_cycle, target_ready); end
        n_checks++; if (busy !== 1'b0 || at_target !== 1'b0) begin n_fail++; $display("FAIL estop_flags busy=%b at=%b want 0/0", busy, at_target); end
        cycle();
        estop = 1'b0; target_valid = 1'b0;
        #1;
        n_checks++; if (target_ready !== 1'b0) begin n_fail++; $display("FAIL estop_still_stopped ready=%b want 0", target_ready); end
        cycle();
        n_checks++; if (target_ready !== 1'b1 || duty_cycle !== 8'sd0 || at_target !== 1'b1) begin n_fail++; $display("FAIL estop_release ready=%b duty=%0d at=%b want 1/0/1", target_ready, duty_cycle, at_target); end
    endtask

    task automatic test_zero_cfg();
        step = 4'd0; interval = 16'd0; target_duty = 8'sd3; target_valid = 1'b1;
        cycle();
        target_valid = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            cycle();
            n_checks++; if (int'(duty_cycle) != e) begin n_fail++; $display("FAIL zero_cfg got %0d want %0d", duty_cycle, e); end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        step = 4'd15; interval = 16'd1; target_duty = 8'sd0; target_valid = 1'b1;
        cycle();
        target_valid = 1'b0;
        cycle();
        step = 4'd10; target_duty = 8'sd100; target_valid = 1'b1;
        cycle();
        target_valid = 1'b0;
        while (m_duty != 70 && guard < 30) begin cycle(); guard++; end
        n_checks++; if (guard >= 30 || duty_cycle !== 8'sd70 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach70 duty=%0d busy=%b want 70/1", duty_cycle, busy); end
        reset = 1'b1;
        cycle();
        n_checks++; if (duty_cycle !== 8'sd0 || busy !== 1'b0 || at_target !== 1'b1) begin n_fail++; $display("FAIL rstmid duty=%0d busy=%b at=%b want 0/0/1", duty_cycle, busy, at_target); end
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            target_valid = ($urandom_range(0, 3) == 0);
            target_duty  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) step = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) interval = 16'($urandom_range(0, 5));
            estop = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 199) == 0);
            #1;
            n_checks++; if (target_ready !== (!reset && !estop && !m_estop)) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, target_ready, !reset && !estop && !m_estop); end
            cycle();
            n_checks++; if (int'(duty_cycle) != m_duty || busy !== m_ramp) begin n_fail++; $display("FAIL rnd_state cyc %0d duty=%0d busy=%b want %0d/%b", i, duty_cycle, busy, m_duty, m_ramp); end
            n_checks++; if (at_target !== (m_duty == m_tgt && !m_estop)) begin n_fail++; $display("FAIL rnd_at_target cyc %0d got %b want %b", i, at_target, (m_duty == m_tgt && !m_estop)); end
            n_checks++; if (int'(duty_cycle) < 0 || int'(duty_cycle) > 100) begin n_fail++; $display("FAIL rnd_range cyc %0d got %0d want 0..100", i, duty_cycle); end
        end
        estop = 1'b0; reset = 1'b0; target_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_basic();
        test_reverse();
        test_clamp();
        test_estop();
        test_zero_cfg();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
